fruit_launcher: RTL and testbench

- Produces the moving-sprite side of the square-sprite collision interface: a projectile (fruit) top-left position x/y on the 640x480 screen, advanced once per video frame under gravity.
- Consumes the collision checker's `collision` result and reports a hit (sliced) or a miss (fell off the bottom).
- Sits between game control (launch requests) and the sprite renderer and collision checker; one instance per on-screen fruit.

---
 rtl/fruit_launcher.sv | 115 +++++++++++
 tb/tb_fruit_launcher.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fruit_launcher.sv
// fruit_launcher: gravity-driven sprite position generator that reports a slice (hit) or a fall-out (miss).
module fruit_launcher #(
   parameter int SIZE       = 50,
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int GRAVITY    = 1,
   parameter int HIT_FRAMES = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       frame_tick_i,
   input  logic       launch_i,
   input  logic [9:0] launch_x_i,
   input  logic [5:0] launch_vx_i,
   input  logic [6:0] launch_vy_i,
   input  logic       collision_i,
   output logic [9:0] x_o,
   output logic [8:0] y_o,
   output logic       active_o,
   output logic       busy_o,
   output logic       hit_o,
   output logic       missed_o
);
   localparam logic [9:0] X_MAX = 10'(SCREEN_W - SIZE);
   localparam logic [8:0] Y_MAX = 9'(SCREEN_H - SIZE);
   localparam logic signed [11:0] NX_MAX = 12'(SCREEN_W - SIZE);
   localparam logic signed [11:0] NY_MAX = 12'(SCREEN_H - SIZE);
   localparam int CW = $clog2(HIT_FRAMES + 1);
   typedef enum logic [1:0] {IDLE, FLIGHT, HIT} state_t;
   state_t state_q, state_d;
   logic [9:0] x_q, x_d;
   logic [8:0] y_q, y_d;
   logic signed [5:0] vx_q, vx_d, vx_neg;
   logic signed [6:0] vy_q, vy_d, vy_g;
   logic signed [7:0] vy_s;
   logic signed [11:0] nx, ny;
   logic [CW-1:0] cnt_q, cnt_d;
   logic hit_q, hit_d, missed_q, missed_d;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         vx_q     <= '0;
         vy_q     <= '0;
         cnt_q    <= '0;
         hit_q    <= 1'b0;
         missed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         vx_q     <= vx_d;
         vy_q     <= vy_d;
         cnt_q    <= cnt_d;
         hit_q    <= hit_d;
         missed_q <= missed_d;
      end
   end
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      vx_d     = vx_q;
      vy_d     = vy_q;
      cnt_d    = cnt_q;
      hit_d    = 1'b0;
      missed_d = 1'b0;
      nx       = $signed({2'b00, x_q}) + $signed({{6{vx_q[5]}}, vx_q});
      ny       = $signed({3'b000, y_q}) + $signed({{5{vy_q[6]}}, vy_q});
      // -32 has no positive counterpart in 6 bits, so the bounce saturates to +31
      vx_neg   = (vx_q == 6'sh20) ? 6'sd31 : -vx_q;
      vy_s     = $signed({vy_q[6], vy_q}) + $signed(8'(GRAVITY));
      vy_g     = (vy_s > 8'sd63) ? 7'sd63 : vy_s[6:0];
      case (state_q)
         IDLE: if (launch_i) begin
            state_d = FLIGHT;
            x_d     = (launch_x_i > X_MAX) ? X_MAX : launch_x_i;
            y_d     = Y_MAX;
            vx_d    = $signed(launch_vx_i);
            vy_d    = $signed(launch_vy_i);
         end
         FLIGHT: if (collision_i) begin
            state_d = HIT;
            hit_d   = 1'b1;
            cnt_d   = '0;
         end else if (frame_tick_i) begin
            x_d  = (nx < 12'sd0) ? 10'd0 : (nx > NX_MAX) ? X_MAX : nx[9:0];
            vx_d = (nx < 12'sd0 || nx > NX_MAX) ? vx_neg : vx_q;
            vy_d = vy_g;
            if (ny < 12'sd0) begin
               y_d  = '0;
               vy_d = '0;
            end else if (ny > NY_MAX && vy_q > 7'sd0) begin
               y_d      = Y_MAX;
               missed_d = 1'b1;
               state_d  = IDLE;
            end else begin
               y_d = ny[8:0];
            end
         end
         HIT: if (frame_tick_i) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(HIT_FRAMES - 1)) ? IDLE : HIT;
         end
         default: state_d = IDLE;
      endcase
   end
   assign x_o      = x_q;
   assign y_o      = y_q;
   assign active_o = (state_q != IDLE);
   assign busy_o   = (state_q != IDLE);
   assign hit_o    = hit_q;
   assign missed_o = missed_q;
endmodule

// File: tb/tb_fruit_launcher.sv
// tb_fruit_launcher: scenario tasks driving per-cycle stimulus tables against a queue of expected outputs.
module tb_fruit_launcher;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       frame_tick = 1'b0, launch = 1'b0, collision = 1'b0;
   logic [9:0] launch_x = '0;
   logic [5:0] launch_vx = '0;
   logic [6:0] launch_vy = '0;
   logic [9:0] x;
   logic [8:0] y;
   logic       active, busy, hit, missed;
   int         checks = 0, passes = 0;
   typedef struct packed {logic [9:0] x; logic [8:0] y; logic a, b, h, m;} obs_t;
   typedef struct packed {logic l, t, c; logic [9:0] lx;} stp_t;
   obs_t exp_q[$];
   fruit_launcher dut (
      .clk_i(clk), .rst_ni(rst_n), .frame_tick_i(frame_tick), .launch_i(launch),
      .launch_x_i(launch_x), .launch_vx_i(launch_vx), .launch_vy_i(launch_vy),
      .collision_i(collision), .x_o(x), .y_o(y), .active_o(active), .busy_o(busy),
      .hit_o(hit), .missed_o(missed)
   );
   always #5 clk = ~clk;
   function automatic obs_t mk(int xx, int yy, logic a, logic b, logic h, logic m);
      return {10'(xx), 9'(yy), a, b, h, m};
   endfunction
   function automatic stp_t s(logic l, logic t, logic c, int lx);
      return {l, t, c, 10'(lx)};
   endfunction
   function automatic obs_t obs();
      return {x, y, active, busy, hit, missed};
   endfunction
   task automatic test_reset();
      obs_t g, e;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1 g = obs(); e = exp_q.pop_front(); checks++;
      if (g !== e) $display("FAIL reset: got x=%0d y=%0d a=%b b=%b h=%b m=%b want x=%0d y=%0d a=%b b=%b h=%b m=%b", g.x, g.y, g.a, g.b, g.h, g.m, e.x, e.y, e.a, e.b, e.h, e.m);
      else passes++;
      rst_n = 1'b1;
   endtask
   task automatic test_nominal_hit();
      stp_t st[$];
      obs_t ex[$];
      obs_t g, e;
      launch_vx = 6'd3; launch_vy = 7'h76;
      st = {s(1,0,0,100), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,1,0), s(0,0,1,0),
            s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,0,0,0), s(0,1,1,0)};
      ex = {mk(100,430,1,1,0,0), mk(103,420,1,1,0,0), mk(106,411,1,1,0,0), mk(109,403,1,1,0,0),
            mk(109,403,1,1,1,0), mk(109,403,1,1,0,0), mk(109,403,1,1,0,0), mk(109,403,1,1,0,0),
            mk(109,403,1,1,0,0), mk(109,403,0,0,0,0), mk(109,403,0,0,0,0), mk(109,403,0,0,0,0)};
      for (int i = 0; i < st.size(); i++) begin
         {launch, frame_tick, collision} = {st[i].l, st[i].t, st[i].c};
         launch_x = st[i].lx;
         exp_q.push_back(ex[i]);
         @(posedge clk); #1;
         {launch, frame_tick, collision} = 3'b000;
         g = obs(); e = exp_q.pop_front(); checks++;
         if (g !== e) $display("FAIL nominal_hit[%0d]: got x=%0d y=%0d a=%b b=%b h=%b m=%b want x=%0d y=%0d a=%b b=%b h=%b m=%b", i, g.x, g.y, g.a, g.b, g.h, g.m, e.x, e.y, e.a, e.b, e.h, e.m);
         else passes++;
      end
   endtask
   task automatic test_wall();
      stp_t st[$];
      obs_t ex[$];
      obs_t g, e;
      launch_vx = 6'd8; launch_vy = 7'h6C;
      st = {s(1,0,0,585), s(0,1,0,0), s(0,1,0,0), s(0,0,1,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0)};
      ex = {mk(585,430,1,1,0,0), mk(590,410,1,1,0,0), mk(582,391,1,1,0,0), mk(582,391,1,1,1,0),
            mk(582,391,1,1,0,0), mk(582,391,1,1,0,0), mk(582,391,1,1,0,0), mk(582,391,0,0,0,0)};
      for (int i = 0; i < st.size(); i++) begin
         {launch, frame_tick, collision} = {st[i].l, st[i].t, st[i].c};
         launch_x = st[i].lx;
         exp_q.push_back(ex[i]);
         @(posedge clk); #1;
         {launch, frame_tick, collision} = 3'b000;
         g = obs(); e = exp_q.pop_front(); checks++;
         if (g !== e) $display("FAIL wall[%0d]: got x=%0d y=%0d a=%b b=%b h=%b m=%b want x=%0d y=%0d a=%b b=%b h=%b m=%b", i, g.x, g.y, g.a, g.b, g.h, g.m, e.x, e.y, e.a, e.b, e.h, e.m);
         else passes++;
      end
   endtask
   task automatic test_left_wall_sat();
      stp_t st[$];
      obs_t ex[$];
      obs_t g, e;
      launch_vx = 6'h20; launch_vy = 7'h7B;
      st = {s(1,0,0,10), s(0,1,0,0), s(0,1,0,0), s(0,0,1,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0)};
      ex = {mk(10,430,1,1,0,0), mk(0,425,1,1,0,0), mk(31,421,1,1,0,0), mk(31,421,1,1,1,0),
            mk(31,421,1,1,0,0), mk(31,421,1,1,0,0), mk(31,421,1,1,0,0), mk(31,421,0,0,0,0)};
      for (int i = 0; i < st.size(); i++) begin
         {launch, frame_tick, collision} = {st[i].l, st[i].t, st[i].c};
         launch_x = st[i].lx;
         exp_q.push_back(ex[i]);
         @(posedge clk); #1;
         {launch, frame_tick, collision} = 3'b000;
         g = obs(); e = exp_q.pop_front(); checks++;
         if (g !== e) $display("FAIL left_wall_sat[%0d]: got x=%0d y=%0d a=%b b=%b h=%b m=%b want x=%0d y=%0d a=%b b=%b h=%b m=%b", i, g.x, g.y, g.a, g.b, g.h, g.m, e.x, e.y, e.a, e.b, e.h, e.m);
         else passes++;
      end
   endtask
   task automatic test_miss();
      stp_t st[$];
      obs_t ex[$];
      obs_t g, e;
      launch_vx = 6'd0; launch_vy = 7'h7E;
      st = {s(1,0,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,0,0,0)};
      ex = {mk(0,430,1,1,0,0), mk(0,428,1,1,0,0), mk(0,427,1,1,0,0), mk(0,427,1,1,0,0),
            mk(0,428,1,1,0,0), mk(0,430,1,1,0,0), mk(0,430,0,0,0,1), mk(0,430,0,0,0,0)};
      for (int i = 0; i < st.size(); i++) begin
         {launch, frame_tick, collision} = {st[i].l, st[i].t, st[i].c};
         launch_x = st[i].lx;
         exp_q.push_back(ex[i]);
         @(posedge clk); #1;
         {launch, frame_tick, collision} = 3'b000;
         g = obs(); e = exp_q.pop_front(); checks++;
         if (g !== e) $display("FAIL miss[%0d]: got x=%0d y=%0d a=%b b=%b h=%b m=%b want x=%0d y=%0d a=%b b=%b h=%b m=%b", i, g.x, g.y, g.a, g.b, g.h, g.m, e.x, e.y, e.a, e.b, e.h, e.m);
         else passes++;
      end
   endtask
   task automatic test_ceiling();
      stp_t st[$];
      obs_t ex[$];
      obs_t g, e;
      launch_vx = 6'd0; launch_vy = 7'h40;
      st = {s(1,0,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0),
            s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,0,1,0), s(0,1,0,0), s(0,1,0,0),
            s(0,1,0,0), s(0,1,0,0)};
      ex = {mk(0,430,1,1,0,0), mk(0,366,1,1,0,0), mk(0,303,1,1,0,0), mk(0,241,1,1,0,0),
            mk(0,180,1,1,0,0), mk(0,120,1,1,0,0), mk(0,61,1,1,0,0), mk(0,3,1,1,0,0),
            mk(0,0,1,1,0,0), mk(0,0,1,1,0,0), mk(0,1,1,1,0,0), mk(0,1,1,1,1,0),
            mk(0,1,1,1,0,0), mk(0,1,1,1,0,0), mk(0,1,1,1,0,0), mk(0,1,0,0,0,0)};
      for (int i = 0; i < st.size(); i++) begin
         {launch, frame_tick, collision} = {st[i].l, st[i].t, st[i].c};
         launch_x = st[i].lx;
         exp_q.push_back(ex[i]);
         @(posedge clk); #1;
         {launch, frame_tick, collision} = 3'b000;
         g = obs(); e = exp_q.pop_front(); checks++;
         if (g !== e) $display("FAIL ceiling[%0d]: got x=%0d y=%0d a=%b b=%b h=%b m=%b want x=%0d y=%0d a=%b b=%b h=%b m=%b", i, g.x, g.y, g.a, g.b, g.h, g.m, e.x, e.y, e.a, e.b, e.h, e.m);
         else passes++;
      end
   endtask
   task automatic test_launch_busy();
      stp_t st[$];
      obs_t ex[$];
      obs_t g, e;
      launch_vx = 6'd3; launch_vy = 7'h76;
      st = {s(1,0,0,100), s(1,1,0,300), s(1,0,0,300), s(0,1,0,0), s(1,0,1,300), s(1,1,0,300),
            s(1,1,0,300), s(1,1,0,300), s(1,1,0,300), s(1,0,0,700), s(0,1,0,0), s(0,1,0,0)};
      ex = {mk(100,430,1,1,0,0), mk(103,420,1,1,0,0), mk(103,420,1,1,0,0), mk(106,411,1,1,0,0),
            mk(106,411,1,1,1,0), mk(106,411,1,1,0,0), mk(106,411,1,1,0,0), mk(106,411,1,1,0,0),
            mk(106,411,0,0,0,0), mk(590,430,1,1,0,0), mk(590,420,1,1,0,0), mk(587,411,1,1,0,0)};
      for (int i = 0; i < st.size(); i++) begin
         {launch, frame_tick, collision} = {st[i].l, st[i].t, st[i].c};
         launch_x = st[i].lx;
         exp_q.push_back(ex[i]);
         @(posedge clk); #1;
         {launch, frame_tick, collision} = 3'b000;
         g = obs(); e = exp_q.pop_front(); checks++;
         if (g !== e) $display("FAIL launch_busy[%0d]: got x=%0d y=%0d a=%b b=%b h=%b m=%b want x=%0d y=%0d a=%b b=%b h=%b m=%b", i, g.x, g.y, g.a, g.b, g.h, g.m, e.x, e.y, e.a, e.b, e.h, e.m);
         else passes++;
      end
   endtask
   task automatic test_reset_mid();
      stp_t st[$];
      obs_t ex[$];
      obs_t g, e;
      #2 rst_n = 1'b0;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      #1 g = obs(); e = exp_q.pop_front(); checks++;
      if (g !== e) $display("FAIL reset_mid: got x=%0d y=%0d a=%b b=%b h=%b m=%b want x=%0d y=%0d a=%b b=%b h=%b m=%b", g.x, g.y, g.a, g.b, g.h, g.m, e.x, e.y, e.a, e.b, e.h, e.m);
      else passes++;
      @(posedge clk); #1 rst_n = 1'b1;
      launch_vx = 6'd3; launch_vy = 7'h76;
      st = {s(1,0,0,100), s(0,1,0,0)};
      ex = {mk(100,430,1,1,0,0), mk(103,420,1,1,0,0)};
      for (int i = 0; i < st.size(); i++) begin
         {launch, frame_tick, collision} = {st[i].l, st[i].t, st[i].c};
         launch_x = st[i].lx;
         exp_q.push_back(ex[i]);
         @(posedge clk); #1;
         {launch, frame_tick, collision} = 3'b000;
         g = obs(); e = exp_q.pop_front(); checks++;
         if (g !== e) $display("FAIL relaunch[%0d]: got x=%0d y=%0d a=%b b=%b h=%b m=%b want x=%0d y=%0d a=%b b=%b h=%b m=%b", i, g.x, g.y, g.a, g.b, g.h, g.m, e.x, e.y, e.a, e.b, e.h, e.m);
         else passes++;
      end
   endtask
   initial begin
      test_reset();
      test_nominal_hit();
      test_wall();
      test_left_wall_sat();
      test_miss();
      test_ceiling();
      test_launch_busy();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
